apb_slave_regfile: RTL and testbench



---
 rtl/apb_slv_pkg.sv | 27 ++
 rtl/apb_slave_regfile_if.sv | 23 ++
 rtl/apb_wait_ctr.sv | 26 ++
 rtl/apb_slave_regfile.sv | 142 ++++++++++++++
 tb/tb_apb_slave_regfile.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/apb_slv_pkg.sv
// rtl/apb_slv_pkg.sv - shared FSM states, address constants and decode helper for the APB register slave
package apb_slv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam int ADDR_LSB = 2;
    localparam int OFFSET_W = 12;
    localparam int IDX_W    = OFFSET_W - ADDR_LSB;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             in_range;
    } dec_t;

    // Word index within the 4 KB window; byte-lane bits and bits above the window are ignored.
    function automatic dec_t addr_decode(input logic [31:0] paddr, input int num_regs);
        dec_t d;
        d.idx      = paddr[OFFSET_W-1:ADDR_LSB];
        d.in_range = (int'({{(32-IDX_W){1'b0}}, d.idx}) < num_regs);
        return d;
    endfunction

endpackage

// File: rtl/apb_slave_regfile_if.sv
// rtl/apb_slave_regfile_if.sv - APB bus bundle between bridge (master) and register slave
interface apb_slave_regfile_if;

    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_wait_ctr.sv
// rtl/apb_wait_ctr.sv - 4-bit loadable down-counter that flags the final wait state
module apb_wait_ctr (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_dec,
    output logic       o_last
);

    logic [3:0] r_count;

    // Load wins over decrement; the count parks at zero rather than wrapping.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_count <= 4'd0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != 4'd0)) begin
            r_count <= r_count - 4'd1;
        end
    end

    assign o_last = (r_count == 4'd1);

endmodule

// File: rtl/apb_slave_regfile.sv
// rtl/apb_slave_regfile.sv - APB register-file slave with wait states and write counter; APB_SLV_ERR_EN enables PSLVERR
module apb_slave_regfile
    import apb_slv_pkg::*;
#(
    parameter int NUM_REGS    = 8,
    parameter int WAIT_CYCLES = 1,
    parameter int CNT_W       = 32
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    apb_slave_regfile_if.slave  bus
);

    localparam int CNT_IDX = NUM_REGS - 1;

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_write;
    logic [31:0]      r_wdata;
    logic             r_in_range;
    logic [31:0]      r_regs [NUM_REGS-1];
    logic [CNT_W-1:0] r_wr_cnt;
    logic [31:0]      r_prdata;
    logic             r_pready;
    logic             r_pslverr;

    dec_t             w_dec;
    logic             w_setup;
    logic             w_load;
    logic             w_ctr_last;
    logic             w_enter_done;
    logic [IDX_W-1:0] w_rd_idx;
    logic             w_rd_write;
    logic             w_rd_in_range;
    logic [31:0]      w_rd_data;
    logic             w_commit;

    assign w_dec   = addr_decode(bus.PADDR, NUM_REGS);
    assign w_setup = bus.PSEL && !bus.PENABLE;
    assign w_load  = (r_state == ST_IDLE) && w_setup && (WAIT_CYCLES != 0);

    apb_wait_ctr u_wait_ctr (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .i_load     (w_load),
        .i_load_val (4'(WAIT_CYCLES)),
        .i_dec      (r_state == ST_WAIT),
        .o_last     (w_ctr_last)
    );

    // With no wait states the read data must come from the live decode, otherwise from the latched setup.
    always_comb begin
        w_enter_done  = ((r_state == ST_IDLE) && w_setup && (WAIT_CYCLES == 0)) ||
                        ((r_state == ST_WAIT) && bus.PSEL && w_ctr_last);
        w_rd_idx      = (r_state == ST_IDLE) ? w_dec.idx      : r_idx;
        w_rd_write    = (r_state == ST_IDLE) ? bus.PWRITE     : r_write;
        w_rd_in_range = (r_state == ST_IDLE) ? w_dec.in_range : r_in_range;
    end

    // Read mux: counter zero-extended, out-of-range reads as zero.
    always_comb begin
        w_rd_data = 32'd0;
        if (w_rd_in_range) begin
            if (w_rd_idx == IDX_W'(CNT_IDX)) begin
                w_rd_data = 32'(r_wr_cnt);
            end else begin
                for (int i = 0; i < NUM_REGS - 1; i++) begin
                    if (w_rd_idx == IDX_W'(i)) w_rd_data = r_regs[i];
                end
            end
        end
    end

`ifdef APB_SLV_ERR_EN
    logic w_err;
    assign w_err = !w_rd_in_range || (w_rd_write && (w_rd_idx == IDX_W'(CNT_IDX)));
`endif

    // A write lands only if the master still holds the access phase when DONE is left.
    assign w_commit = (r_state == ST_DONE) && r_write && bus.PSEL && bus.PENABLE &&
                      r_in_range && (r_idx != IDX_W'(CNT_IDX));

    // Transfer FSM with registered PREADY/PRDATA/PSLVERR, all valid only in the DONE cycle.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_write    <= 1'b0;
            r_wdata    <= 32'd0;
            r_in_range <= 1'b0;
            r_prdata   <= 32'd0;
            r_pready   <= 1'b0;
            r_pslverr  <= 1'b0;
        end else begin
            r_pready <= w_enter_done;
            r_prdata <= (w_enter_done && !w_rd_write) ? w_rd_data : 32'd0;
`ifdef APB_SLV_ERR_EN
            r_pslverr <= w_enter_done && w_err;
`else
            r_pslverr <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_setup) begin
                        r_idx      <= w_dec.idx;
                        r_write    <= bus.PWRITE;
                        r_wdata    <= bus.PWDATA;
                        r_in_range <= w_dec.in_range;
                        r_state    <= (WAIT_CYCLES == 0) ? ST_DONE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!bus.PSEL) begin
                        r_state <= ST_IDLE;
                    end else if (w_ctr_last) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Register bank and write counter; the counter wraps naturally at CNT_W bits.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < NUM_REGS - 1; i++) r_regs[i] <= 32'd0;
            r_wr_cnt <= '0;
        end else if (w_commit) begin
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                if (r_idx == IDX_W'(i)) r_regs[i] <= r_wdata;
            end
            r_wr_cnt <= r_wr_cnt + CNT_W'(1);
        end
    end

    assign bus.PRDATA  = r_prdata;
    assign bus.PREADY  = r_pready;
    assign bus.PSLVERR = r_pslverr;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb/tb_apb_slave_regfile.sv - directed scoreboard bench for apb_slave_regfile, follows APB_SLV_ERR_EN
module tb_apb_slave_regfile;

`ifdef APB_SLV_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        HCLK    = 1'b0;
    logic        HRESETn = 1'b1;
    logic        b_psel = 1'b0, b_penable = 1'b0, b_pwrite = 1'b0;
    logic [31:0] b_paddr = 32'd0, b_pwdata = 32'd0;
    int          sel = 0;

    always #5 HCLK = ~HCLK;

    apb_slave_regfile_if if0 ();
    apb_slave_regfile_if if1 ();
    apb_slave_regfile_if if2 ();

    assign if0.PSEL = b_psel && (sel == 0);
    assign if1.PSEL = b_psel && (sel == 1);
    assign if2.PSEL = b_psel && (sel == 2);
    assign if0.PENABLE = b_penable;  assign if1.PENABLE = b_penable;  assign if2.PENABLE = b_penable;
    assign if0.PWRITE  = b_pwrite;   assign if1.PWRITE  = b_pwrite;   assign if2.PWRITE  = b_pwrite;
    assign if0.PADDR   = b_paddr;    assign if1.PADDR   = b_paddr;    assign if2.PADDR   = b_paddr;
    assign if0.PWDATA  = b_pwdata;   assign if1.PWDATA  = b_pwdata;   assign if2.PWDATA  = b_pwdata;

    apb_slave_regfile #(.NUM_REGS(8), .WAIT_CYCLES(1), .CNT_W(32)) dut0 (.HCLK(HCLK), .HRESETn(HRESETn), .bus(if0.slave));
    apb_slave_regfile #(.NUM_REGS(8), .WAIT_CYCLES(0), .CNT_W(32)) dut1 (.HCLK(HCLK), .HRESETn(HRESETn), .bus(if1.slave));
    apb_slave_regfile #(.NUM_REGS(8), .WAIT_CYCLES(3), .CNT_W(4))  dut2 (.HCLK(HCLK), .HRESETn(HRESETn), .bus(if2.slave));

    logic [31:0] m_prdata;
    logic        m_pready, m_pslverr;

    always_comb begin
        m_prdata = if0.PRDATA; m_pready = if0.PREADY; m_pslverr = if0.PSLVERR;
        if (sel == 1) begin
            m_prdata = if1.PRDATA; m_pready = if1.PREADY; m_pslverr = if1.PSLVERR;
        end else if (sel == 2) begin
            m_prdata = if2.PRDATA; m_pready = if2.PREADY; m_pslverr = if2.PSLVERR;
        end
    end

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        chk_rdata;
        logic        err;
        int          cycles;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int waits_of(input int s);
        return (s == 0) ? 1 : (s == 1) ? 0 : 3;
    endfunction

    // Called in the drive slot just after a rising edge; returns in the drive slot after the transfer.
    task automatic xfer(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        exp_t got;
        int   n;
        e.rdata     = exp_rd;
        e.chk_rdata = !wr;
        e.err       = ERR_EN && exp_err;
        e.cycles    = waits_of(sel) + 1;
        sb.push_back(e);
        b_psel = 1'b1; b_penable = 1'b0; b_pwrite = wr; b_paddr = addr; b_pwdata = wdata;
        @(posedge HCLK); #1;
        b_penable = 1'b1;
        n = 1;
        @(negedge HCLK);
        while (!m_pready && n < 20) begin
            @(posedge HCLK); #1;
            n++;
            @(negedge HCLK);
        end
        got = sb.pop_front();
        check({tag, ":cycles"}, n, got.cycles);
        if (got.chk_rdata) check({tag, ":prdata"}, m_prdata, got.rdata);
        check({tag, ":pslverr"}, {31'd0, m_pslverr}, {31'd0, got.err});
        @(posedge HCLK); #1;
    endtask

    task automatic idle(input int k);
        b_psel = 1'b0; b_penable = 1'b0;
        for (int i = 0; i < k; i++) begin
            @(negedge HCLK);
            check("idle_pready", {31'd0, m_pready}, 32'd0);
            @(posedge HCLK); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 HRESETn = 1'b0;
        @(negedge HCLK);
        check("rst_pready",  {31'd0, m_pready},  32'd0);
        check("rst_prdata",  m_prdata,           32'd0);
        check("rst_pslverr", {31'd0, m_pslverr}, 32'd0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        idle(2);

        sel = 0;
        for (int i = 0; i < 8; i++) xfer($sformatf("rst_rd%0d", i), 1'b0, 32'(i * 4), 32'd0, 32'd0, 1'b0);
        xfer("w1_wr4",     1'b1, 32'h4,    32'hDEADBEEF, 32'd0,        1'b0);
        xfer("w1_rd4",     1'b0, 32'h4,    32'd0,        32'hDEADBEEF, 1'b0);
        xfer("w1_cnt",     1'b0, 32'h1C,   32'd0,        32'd1,        1'b0);
        xfer("w1_rd7",     1'b0, 32'h7,    32'd0,        32'hDEADBEEF, 1'b0);
        xfer("w1_rd1004",  1'b0, 32'h1004, 32'd0,        32'hDEADBEEF, 1'b0);
        idle(1);
        xfer("err_wr20",   1'b1, 32'h20,   32'h1,        32'd0,        1'b1);
        xfer("err_wrcnt",  1'b1, 32'h1C,   32'h5,        32'd0,        1'b1);
        xfer("err_cnt",    1'b0, 32'h1C,   32'd0,        32'd1,        1'b0);
        xfer("err_rd20",   1'b0, 32'h20,   32'd0,        32'd0,        1'b1);
        xfer("err_rd3fc",  1'b0, 32'h3FC,  32'd0,        32'd0,        1'b1);
        xfer("err_rd4",    1'b0, 32'h4,    32'd0,        32'hDEADBEEF, 1'b0);

        b_psel = 1'b1; b_penable = 1'b1; b_pwrite = 1'b1; b_paddr = 32'h0; b_pwdata = 32'h55AA55AA;
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            check("stray_pready", {31'd0, m_pready}, 32'd0);
            @(posedge HCLK); #1;
        end
        idle(1);
        xfer("stray_rd0",  1'b0, 32'h0,    32'd0,        32'd0,        1'b0);
        xfer("stray_cnt",  1'b0, 32'h1C,   32'd0,        32'd1,        1'b0);
        idle(1);

        sel = 1;
        xfer("b2b_wr0",    1'b1, 32'h0,    32'h11111111, 32'd0,        1'b0);
        xfer("b2b_wr8",    1'b1, 32'h8,    32'h22222222, 32'd0,        1'b0);
        xfer("b2b_wr10",   1'b1, 32'h10,   32'h33333333, 32'd0,        1'b0);
        idle(1);
        xfer("b2b_cnt",    1'b0, 32'h1C,   32'd0,        32'd3,        1'b0);
        xfer("b2b_rd0",    1'b0, 32'h0,    32'd0,        32'h11111111, 1'b0);
        xfer("b2b_rd8",    1'b0, 32'h8,    32'd0,        32'h22222222, 1'b0);
        xfer("b2b_rd10",   1'b0, 32'h10,   32'd0,        32'h33333333, 1'b0);
        idle(1);

        sel = 2;
        xfer("w3_wr8",     1'b1, 32'h8,    32'hA5A5A5A5, 32'd0,        1'b0);
        idle(1);
        b_psel = 1'b1; b_penable = 1'b0; b_pwrite = 1'b1; b_paddr = 32'h8; b_pwdata = 32'h12345678;
        @(posedge HCLK); #1;
        b_penable = 1'b1;
        @(negedge HCLK);
        check("abort_pready", {31'd0, m_pready}, 32'd0);
        @(posedge HCLK); #1;
        idle(3);
        xfer("abort_rd8",  1'b0, 32'h8,    32'd0,        32'hA5A5A5A5, 1'b0);
        xfer("abort_cnt",  1'b0, 32'h1C,   32'd0,        32'd1,        1'b0);
        for (int i = 0; i < 16; i++) xfer("wrap_wr", 1'b1, 32'hC, 32'(i), 32'd0, 1'b0);
        idle(1);
        xfer("wrap_cnt",   1'b0, 32'h1C,   32'd0,        32'd1,        1'b0);
        xfer("wrap_rdc",   1'b0, 32'hC,    32'd0,        32'd15,       1'b0);

        b_psel = 1'b1; b_penable = 1'b0; b_pwrite = 1'b1; b_paddr = 32'h10; b_pwdata = 32'hCAFEF00D;
        @(posedge HCLK); #1;
        b_penable = 1'b1;
        @(posedge HCLK); #1;
        HRESETn = 1'b0;
        @(negedge HCLK);
        check("mrst_pready",  {31'd0, m_pready},  32'd0);
        check("mrst_prdata",  m_prdata,           32'd0);
        check("mrst_pslverr", {31'd0, m_pslverr}, 32'd0);
        b_psel = 1'b0; b_penable = 1'b0;
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        idle(1);
        xfer("mrst_cnt",   1'b0, 32'h1C,   32'd0,        32'd0,        1'b0);
        xfer("mrst_rd8",   1'b0, 32'h8,    32'd0,        32'd0,        1'b0);
        xfer("mrst_rd10",  1'b0, 32'h10,   32'd0,        32'd0,        1'b0);
        idle(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
